// File: rtl/uop_queue.sv
// Micro-op bundle queue: circular FIFO of decoded bundles feeding the reservation station.
// Optional macro UOPQ_BYPASS_EN lets an empty queue forward the decoder bundle combinationally.
module uop_queue #(
    parameter int          DEPTH = 4,
    parameter logic [19:0] NOP   = 20'h00F00
) (
    input  logic                     clk,
    input  logic                     a_rst,
    input  logic                     dec_valid,
    output logic                     dec_ready,
    input  logic [19:0]              dec_uop_0,
    input  logic [19:0]              dec_uop_1,
    input  logic [19:0]              dec_uop_2,
    input  logic [1:0]               dec_uop_count,
    input  logic [15:0]              dec_k16,
    input  logic                     flush,
    input  logic                     id_feed_req,
    output logic [19:0]              id_uop_0,
    output logic [19:0]              id_uop_1,
    output logic [19:0]              id_uop_2,
    output logic [1:0]               id_uop_count,
    output logic [15:0]              id_k16,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [19:0] uop_0;
        logic [19:0] uop_1;
        logic [19:0] uop_2;
        logic [1:0]  count;
        logic [15:0] k16;
    } entry_t;

    localparam entry_t EMPTY_BUNDLE = '{uop_0: NOP, uop_1: NOP, uop_2: NOP, count: 2'd0, k16: 16'd0};

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     occ_q, occ_d;
    logic            full, empty, bundle_ok, bypass, push, pop;
    entry_t          wr_entry, head, id_bundle;

    assign wr_entry  = '{uop_0: dec_uop_0, uop_1: dec_uop_1, uop_2: dec_uop_2,
                         count: dec_uop_count, k16: dec_k16};

    assign full      = (occ_q == FULL_CNT);
    assign empty     = (occ_q == '0);
    assign dec_ready = ~full;
    assign occupancy = occ_q;

    // A zero-count bundle is handshaken but never stored.
    assign bundle_ok = dec_valid & (dec_uop_count != 2'd0) & ~flush;

`ifdef UOPQ_BYPASS_EN
    assign bypass = empty & bundle_ok;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed bundle consumed in the same cycle never enters storage.
    assign push = bundle_ok & dec_ready & ~(bypass & id_feed_req);
    assign pop  = id_feed_req & ~empty & ~flush;

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // NOTE: storage is deliberately not reset; zeroed pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        id_bundle = EMPTY_BUNDLE;
        if (!empty)      id_bundle = head;
        else if (bypass) id_bundle = wr_entry;
    end

    assign id_uop_0     = id_bundle.uop_0;
    assign id_uop_1     = id_bundle.uop_1;
    assign id_uop_2     = id_bundle.uop_2;
    assign id_uop_count = id_bundle.count;
    assign id_k16       = id_bundle.k16;

endmodule

// File: tb/tb_uop_queue.sv
// Scoreboard bench for uop_queue: stimulus pushes expected bundles, a negedge monitor pops and compares.
module tb_uop_queue;

    localparam int          DEPTH = 4;
    localparam logic [19:0] NOP   = 20'h00F00;
`ifdef UOPQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        a_rst;
    logic        dec_valid, dec_ready;
    logic [19:0] dec_uop_0, dec_uop_1, dec_uop_2;
    logic [1:0]  dec_uop_count;
    logic [15:0] dec_k16;
    logic        flush, id_feed_req;
    logic [19:0] id_uop_0, id_uop_1, id_uop_2;
    logic [1:0]  id_uop_count;
    logic [15:0] id_k16;
    logic [2:0]  occupancy;

    uop_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk(clk), .a_rst(a_rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_uop_0(dec_uop_0), .dec_uop_1(dec_uop_1), .dec_uop_2(dec_uop_2),
        .dec_uop_count(dec_uop_count), .dec_k16(dec_k16),
        .flush(flush), .id_feed_req(id_feed_req),
        .id_uop_0(id_uop_0), .id_uop_1(id_uop_1), .id_uop_2(id_uop_2),
        .id_uop_count(id_uop_count), .id_k16(id_k16),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] u0;
        logic [19:0] u1;
        logic [19:0] u2;
        logic [1:0]  cnt;
        logic [15:0] k;
    } bundle_t;

    bundle_t exp_q[$];
    bundle_t byp_item, store_item;
    bit      byp_exp, exp_store, exp_pop;
    int      model_occ;
    int      n_pass, n_total;

    function automatic bundle_t mk(input logic [15:0] k, input logic [1:0] cnt);
        bundle_t b;
        b.u0 = {k, 4'h0};
        b.u1 = {k, 4'h1};
        b.u2 = {k, 4'h2};
        b.cnt = cnt;
        b.k = k;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Apply one cycle of stimulus, predict its effect, and return just after the sampling edge.
    task automatic drive(input bit v, input logic [1:0] cnt, input logic [15:0] k,
                         input bit feed, input bit fl);
        bundle_t b;
        b = mk(k, cnt);
        dec_valid     = v;
        dec_uop_0     = b.u0;
        dec_uop_1     = b.u1;
        dec_uop_2     = b.u2;
        dec_uop_count = cnt;
        dec_k16       = k;
        id_feed_req   = feed;
        flush         = fl;
        byp_exp    = BYP && model_occ == 0 && v && cnt != 2'd0 && !fl;
        byp_item   = b;
        exp_store  = v && cnt != 2'd0 && model_occ != DEPTH && !fl && !(byp_exp && feed);
        store_item = b;
        exp_pop    = feed && !fl && model_occ != 0;
        @(negedge clk);
        #1;
    endtask

    task automatic commit();
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
            model_occ = 0;
        end else begin
            if (exp_store) exp_q.push_back(store_item);
            model_occ = model_occ + int'(exp_store) - int'(exp_pop);
        end
        byp_exp = 1'b0;
        #1;
    endtask

    task automatic cyc(input bit v, input logic [1:0] cnt, input logic [15:0] k,
                       input bit feed, input bit fl);
        drive(v, cnt, k, feed, fl);
        commit();
    endtask

    always @(negedge clk) begin : monitor
        bit      has;
        bundle_t e;
        if (a_rst) begin
            has = (exp_q.size() != 0) || byp_exp;
            e   = (exp_q.size() != 0) ? exp_q[0] : byp_item;
            check("occupancy", 32'(occupancy), 32'(model_occ));
            check("dec_ready", 32'(dec_ready), 32'(model_occ != DEPTH));
            check("head_present", 32'(id_uop_count != 2'd0), 32'(has));
            if (has) begin
                check("head_k16", 32'(id_k16), 32'(e.k));
                check("head_count", 32'(id_uop_count), 32'(e.cnt));
                check("head_uop0", 32'(id_uop_0), 32'(e.u0));
                check("head_uop1", 32'(id_uop_1), 32'(e.u1));
                check("head_uop2", 32'(id_uop_2), 32'(e.u2));
                if (id_feed_req && !flush && exp_q.size() != 0) void'(exp_q.pop_front());
            end else begin
                check("empty_uop0", 32'(id_uop_0), 32'(NOP));
                check("empty_uop1", 32'(id_uop_1), 32'(NOP));
                check("empty_uop2", 32'(id_uop_2), 32'(NOP));
                check("empty_k16", 32'(id_k16), 32'h0);
            end
        end
    end

    initial begin
        a_rst = 1'b0;
        dec_valid = 1'b0; dec_uop_0 = '0; dec_uop_1 = '0; dec_uop_2 = '0;
        dec_uop_count = '0; dec_k16 = '0; flush = 1'b0; id_feed_req = 1'b0;
        model_occ = 0; n_pass = 0; n_total = 0;
        byp_exp = 1'b0; exp_store = 1'b0; exp_pop = 1'b0;

        // Reset held: empty bundle, ready, nothing stored.
        repeat (2) @(posedge clk);
        #1;
        check("rst_uop0", 32'(id_uop_0), 32'h00F00);
        check("rst_uop2", 32'(id_uop_2), 32'h00F00);
        check("rst_count", 32'(id_uop_count), 32'h0);
        check("rst_k16", 32'(id_k16), 32'h0);
        check("rst_ready", 32'(dec_ready), 32'h1);
        check("rst_occ", 32'(occupancy), 32'h0);
        a_rst = 1'b1;
        cyc(0, 2'd0, 16'h0, 0, 0);

        // Fill to full with feed low, then drain on consecutive cycles.
        for (int i = 1; i <= 4; i++) cyc(1, 2'd3, 16'(16'h1111 * i), 0, 0);
        drive(0, 2'd0, 16'h0, 0, 0);
        check("full_occ", 32'(occupancy), 32'h4);
        check("full_ready", 32'(dec_ready), 32'h0);
        commit();
        for (int i = 0; i < 5; i++) begin
            drive(0, 2'd0, 16'h0, 1, 0);
            if (i < 4) check("drain_k16", 32'(id_k16), 32'(16'h1111 * (i + 1)));
            else       check("drain_empty", 32'(id_uop_count), 32'h0);
            commit();
        end

        // Full queue with push and feed together: one pop only.
        for (int i = 1; i <= 4; i++) cyc(1, 2'd3, 16'(16'hA000 + i), 0, 0);
        drive(1, 2'd3, 16'hAFFF, 1, 0);
        check("fullpp_ready", 32'(dec_ready), 32'h0);
        commit();
        drive(0, 2'd0, 16'h0, 0, 0);
        check("fullpp_occ", 32'(occupancy), 32'h3);
        check("fullpp_ready_next", 32'(dec_ready), 32'h1);
        commit();
        repeat (3) cyc(0, 2'd0, 16'h0, 1, 0);

        // Occupancy 2, simultaneous push/pop across pointer wrap.
        cyc(1, 2'd3, 16'h5000, 0, 0);
        cyc(1, 2'd3, 16'h5001, 0, 0);
        for (int i = 2; i < 12; i++) begin
            drive(1, 2'd3, 16'(16'h5000 + i), 1, 0);
            check("pp_occ", 32'(occupancy), 32'h2);
            commit();
        end
        repeat (2) cyc(0, 2'd0, 16'h0, 1, 0);

        // Zero-count bundle is accepted and dropped; flush beats a push.
        cyc(1, 2'd3, 16'h6001, 0, 0);
        drive(1, 2'd0, 16'h0C0C, 0, 0);
        check("zero_ready", 32'(dec_ready), 32'h1);
        commit();
        drive(0, 2'd0, 16'h0, 0, 0);
        check("zero_occ", 32'(occupancy), 32'h1);
        commit();
        cyc(1, 2'd3, 16'h6002, 0, 0);
        cyc(1, 2'd3, 16'h6003, 0, 0);
        drive(1, 2'd3, 16'hDEAD, 0, 1);
        check("preflush_occ", 32'(occupancy), 32'h3);
        commit();
        drive(0, 2'd0, 16'h0, 0, 0);
        check("flush_occ", 32'(occupancy), 32'h0);
        check("flush_count", 32'(id_uop_count), 32'h0);
        commit();

        // Push into empty queue with feed high: bypass or 1-cycle latency.
        drive(1, 2'd3, 16'hBEEF, 1, 0);
        check("beef_k16_now", 32'(id_k16), BYP ? 32'hBEEF : 32'h0);
        commit();
        drive(0, 2'd0, 16'h0, 1, 0);
        check("beef_k16_next", 32'(id_k16), BYP ? 32'h0 : 32'hBEEF);
        commit();
        drive(0, 2'd0, 16'h0, 0, 0);
        check("beef_occ", 32'(occupancy), 32'h0);
        commit();

        // Asynchronous reset mid-operation discards everything at once.
        cyc(1, 2'd3, 16'h7001, 0, 0);
        cyc(1, 2'd3, 16'h7002, 0, 0);
        drive(0, 2'd0, 16'h0, 0, 0);
        #2 a_rst = 1'b0;
        #1;
        check("mrst_occ", 32'(occupancy), 32'h0);
        check("mrst_count", 32'(id_uop_count), 32'h0);
        check("mrst_k16", 32'(id_k16), 32'h0);
        check("mrst_ready", 32'(dec_ready), 32'h1);
        exp_q.delete();
        model_occ = 0;
        @(posedge clk);
        #1;
        check("mrst_held_uop0", 32'(id_uop_0), 32'h00F00);
        a_rst = 1'b1;
        repeat (2) cyc(0, 2'd0, 16'h0, 1, 0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uop_queue.md
UOP_QUEUE -- requirements
Module: uop_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of bundle entries; power of two, minimum 2.
REQ-002 Parameter: NOP, 20'h00F00, micro-op presented in unused/empty slots.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: a_rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: dec_valid  input  1  decoder offers a bundle this cycle.
REQ-006 Port: dec_ready  output  1  queue accepts a bundle this cycle.
REQ-007 Port: dec_uop_0 / dec_uop_1 / dec_uop_2  input  20 each  micro-ops of the offered bundle, in execution order 0,1,2.
REQ-008 Port: dec_uop_count  input  2  number of valid micro-ops in the offered bundle (0-3).
REQ-009 Port: dec_k16  input  16  immediate/operand of the offered bundle.
REQ-010 Port: flush  input  1  synchronous discard of all queued bundles.
REQ-011 Port: id_feed_req  input  1  reservation station requests a new bundle; it loads on the same edge.
REQ-012 Port: id_uop_0 / id_uop_1 / id_uop_2  output  20 each  head bundle micro-ops.
REQ-013 Port: id_uop_count  output  2  head bundle count; 0 means no bundle.
REQ-014 Port: id_k16  output  16  head bundle immediate.
REQ-015 Port: occupancy  output  $clog2(DEPTH)+1  number of stored bundles.

Function
REQ-016 Storage SHALL be a circular FIFO of DEPTH 78-bit entries {uop_0, uop_1, uop_2, count, k16}, with read/write pointers wrapping modulo DEPTH.
REQ-017 dec_ready SHALL equal ~full (occupancy == DEPTH), independent of id_feed_req.
REQ-018 push = dec_valid & dec_ready & (dec_uop_count != 0) & ~flush; a dec_valid bundle with count 0 SHALL be accepted (dec_ready honoured) and discarded.
REQ-019 pop = id_feed_req & ~empty & ~flush; the popped entry SHALL be the one presented on id_* during that cycle.
REQ-020 When not empty, id_* SHALL present the head entry combinationally from storage.
REQ-021 When empty (and no bypass per REQ-028), id_uop_0..2 SHALL be NOP, id_uop_count 0, id_k16 0.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged and advance both pointers; order SHALL be strictly FIFO.
REQ-023 Push while full is impossible (dec_ready low); pop while full SHALL raise dec_ready on the next cycle.
REQ-024 flush SHALL, on the next edge, set both pointers and occupancy to 0, overriding any push or pop that cycle; id_* SHALL show the empty bundle from the following cycle.
REQ-025 occupancy SHALL be registered and equal pushes minus pops since reset/flush, range 0..DEPTH.

Reset
REQ-026 Assertion of a_rst SHALL immediately set pointers and occupancy to 0; dec_ready reads 1, id_* read the empty bundle (NOP, 0, 0) while reset is held and after release.
REQ-027 Storage contents need not be reset; reset mid-operation SHALL discard all queued bundles with no partial output.

Configuration
REQ-028 With UOPQ_BYPASS_EN defined: when empty and dec_valid with nonzero count, id_* SHALL show the decoder bundle combinationally; if id_feed_req is also high the bundle SHALL be consumed without being stored (occupancy stays 0). Otherwise it is stored normally. flush still suppresses the bypass.
REQ-029 Without UOPQ_BYPASS_EN: a pushed bundle SHALL appear on id_* no earlier than the cycle after the push edge (1-cycle minimum latency).

Verification
REQ-030 Reset, idle: id_uop_0..2 = 20'h00F00, id_uop_count = 0, id_k16 = 0, dec_ready = 1, occupancy = 0.
REQ-031 Push 4 bundles (k16 = 16'h1111..16'h4444, count 3) with id_feed_req low -> occupancy 4, dec_ready 0; then hold id_feed_req high -> k16 appears as 1111, 2222, 3333, 4444 on consecutive cycles, then empty bundle.
REQ-032 Full queue, push and feed_req both high -> one pop, no push; next cycle occupancy 3, dec_ready 1.
REQ-033 Occupancy 2, push and pop the same cycle -> occupancy stays 2, FIFO order preserved across pointer wrap over 10 bundles.
REQ-034 dec_valid with dec_uop_count = 0 -> dec_ready 1, occupancy unchanged; flush with occupancy 3 plus simultaneous push -> occupancy 0 next cycle.
REQ-035 Empty queue, push k16 = 16'hBEEF with id_feed_req high -> with UOPQ_BYPASS_EN id_k16 = BEEF same cycle, occupancy stays 0; without it, id_k16 = 0 that cycle and BEEF the next.
